// File: rtl/ila_capture_seq_if.sv
// Channel-side trigger/data inputs and the shared ILA probe bus driven by the capture sequencer.
interface ila_capture_seq_if #(
    parameter int NCH = 4,
    parameter int AW  = 16,
    parameter int DW  = 32
);
    localparam int LW = $clog2(NCH);

    logic [NCH-1:0]    trig_in;
    logic [NCH*AW-1:0] a_in;
    logic [NCH*DW-1:0] d_in;
    logic [AW-1:0]     ila_a;
    logic [DW-1:0]     ila_d;
    logic [LW-1:0]     ila_ch;
    logic              ila_valid;
    logic              ila_trig;

    modport master (
        input  trig_in, a_in, d_in,
        output ila_a, ila_d, ila_ch, ila_valid, ila_trig
    );

    modport slave (
        output trig_in, a_in, d_in,
        input  ila_a, ila_d, ila_ch, ila_valid, ila_trig
    );
endinterface

// File: rtl/ila_capture_seq.sv
// Arms on command, waits for a masked channel trigger, then grants the ILA probe bus to one
// channel for a post-trigger window followed by a holdoff.
module ila_capture_seq #(
    parameter int NCH = 4,
    parameter int AW  = 16,
    parameter int DW  = 32,
    parameter int CW  = 12,
    localparam int LW = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                arm,
    input  logic                abort,
    input  logic                mode_rr,
    input  logic                cont,
    input  logic [LW-1:0]       chan_sel,
    input  logic [NCH-1:0]      trig_mask,
    input  logic [CW-1:0]       post_len,
    input  logic [CW-1:0]       holdoff,
    output logic [1:0]          state,
    output logic                done,
    output logic [15:0]         cap_cnt,
    ila_capture_seq_if.master   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, HOLDOFF = 2'd3} state_e;

    state_e         st;
    logic [LW-1:0]  grant, last, rr_pick, pick, idx, sel_ch;
    logic [CW-1:0]  rem, hcnt, hold_lat;
    logic           cont_lat, rr_hit, fire;
    logic [NCH-1:0] req;

    assign state = st;
    assign req   = bus.trig_in & trig_mask;

    // Round-robin scan starts just past the last granted channel; NCH is a power of 2 so
    // the index wraps by truncation.
    always_comb begin
        rr_pick = last;
        rr_hit  = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = last + LW'(i);
            if (!rr_hit && req[idx]) begin
                rr_pick = idx;
                rr_hit  = 1'b1;
            end
        end
    end

    assign fire   = mode_rr ? rr_hit : req[chan_sel];
    assign pick   = mode_rr ? rr_pick : chan_sel;
    assign sel_ch = (st == CAPTURE) ? grant : pick;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st            <= IDLE;
            grant         <= '0;
            last          <= LW'(NCH - 1);
            rem           <= '0;
            hcnt          <= '0;
            hold_lat      <= '0;
            cont_lat      <= 1'b0;
            done          <= 1'b0;
            cap_cnt       <= '0;
            bus.ila_a     <= '0;
            bus.ila_d     <= '0;
            bus.ila_ch    <= '0;
            bus.ila_valid <= 1'b0;
            bus.ila_trig  <= 1'b0;
        end else begin
            done         <= 1'b0;
            bus.ila_trig <= 1'b0;
            if (abort) begin
                st            <= IDLE;
                bus.ila_valid <= 1'b0;
            end else begin
                case (st)
                    IDLE: if (arm) st <= ARMED;
                    ARMED: if (fire) begin
                        grant         <= pick;
                        if (mode_rr) last <= pick;
                        // rem counts samples still to take after the trigger-cycle sample
                        rem           <= (post_len == '0) ? '0 : post_len - CW'(1);
                        hold_lat      <= holdoff;
                        cont_lat      <= cont;
                        bus.ila_a     <= bus.a_in[sel_ch*AW +: AW];
                        bus.ila_d     <= bus.d_in[sel_ch*DW +: DW];
                        bus.ila_ch    <= pick;
                        bus.ila_valid <= 1'b1;
                        bus.ila_trig  <= 1'b1;
                        st            <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (rem != '0) begin
                            rem       <= rem - CW'(1);
                            bus.ila_a <= bus.a_in[sel_ch*AW +: AW];
                            bus.ila_d <= bus.d_in[sel_ch*DW +: DW];
                        end else begin
                            bus.ila_valid <= 1'b0;
                            hcnt          <= hold_lat;
                            st            <= HOLDOFF;
                            if (hold_lat == '0) begin
                                done    <= 1'b1;
                                cap_cnt <= cap_cnt + 16'd1;
                            end
                        end
                    end
                    HOLDOFF: begin
                        // done is raised one cycle early so it is visible while hcnt==0
                        if (hcnt == '0) begin
                            st <= cont_lat ? ARMED : IDLE;
                        end else begin
                            hcnt <= hcnt - CW'(1);
                            if (hcnt == CW'(1)) begin
                                done    <= 1'b1;
                                cap_cnt <= cap_cnt + 16'd1;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule
